// File: rtl/puf_challenge_sequencer.sv
// Walks the set bits of a 16-bit challenge mask through an RO measurement engine
// (reset, measure window, sample) and collects one response bit per challenge.
// Optional: define PUF_SEQ_MAJORITY_EN for a 3-pass majority vote per challenge.
module puf_challenge_sequencer #(
  parameter int unsigned WINDOW     = 20000000,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] chal_mask,
  output logic        busy,
  output logic        done,
  output logic [15:0] response,
  output logic        meas_rst,
  output logic        meas_valid,
  output logic [3:0]  meas_challenge,
  input  logic        meas_bit
);

  typedef enum logic [2:0] {IDLE, RESET_ENG, MEASURE, SAMPLE, DONE} state_t;

  localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0] WIN_LAST = 32'(WINDOW - 1);

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [15:0] pend;
  logic [3:0]  chal;
  logic        accept;
  logic [15:0] pend_left;
  logic        last_pass;
  logic        res_bit;

  function automatic logic [3:0] lowest(input logic [15:0] m);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--)
      if (m[i]) idx = 4'(i);
    return idx;
  endfunction

  assign accept         = (state == IDLE) && start && !abort;
  assign pend_left      = pend & ~(16'd1 << chal);
  assign meas_challenge = chal;

`ifdef PUF_SEQ_MAJORITY_EN
  logic [1:0] pass;
  logic [1:0] smp;
  assign last_pass = (pass == 2'd2);
  assign res_bit   = (smp[0] & smp[1]) | (smp[0] & meas_bit) | (smp[1] & meas_bit);
`else
  assign last_pass = 1'b1;
  assign res_bit   = meas_bit;
`endif

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b0;
    done       = 1'b0;
    meas_rst   = 1'b1;
    meas_valid = 1'b0;
    case (state)
      IDLE:      if (accept) state_nxt = (chal_mask == 16'd0) ? DONE : RESET_ENG;
      RESET_ENG: begin
        busy = 1'b1;
        if (cnt == RST_LAST) state_nxt = MEASURE;
      end
      MEASURE: begin
        busy       = 1'b1;
        meas_rst   = 1'b0;
        meas_valid = 1'b1;
        if (cnt == WIN_LAST) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        busy       = 1'b1;
        meas_rst   = 1'b0;
        meas_valid = 1'b1;
        state_nxt  = (!last_pass || pend_left != 16'd0) ? RESET_ENG : DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default:   state_nxt = IDLE;
    endcase
    // abort wins over every transition, including a pending SAMPLE write
    if (state != IDLE && abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt      <= 32'd0;
      pend     <= 16'd0;
      chal     <= 4'd0;
      response <= 16'd0;
`ifdef PUF_SEQ_MAJORITY_EN
      pass     <= 2'd0;
      smp      <= 2'd0;
`endif
    end else begin
      if (state_nxt == state && (state == RESET_ENG || state == MEASURE))
        cnt <= cnt + 32'd1;
      else
        cnt <= 32'd0;

      if (accept) begin
        pend     <= chal_mask;
        chal     <= lowest(chal_mask);
        response <= 16'd0;
`ifdef PUF_SEQ_MAJORITY_EN
        pass     <= 2'd0;
`endif
      end

      if (state == SAMPLE && !abort) begin
        if (last_pass) begin
          response[chal] <= res_bit;
          pend           <= pend_left;
          if (pend_left != 16'd0) chal <= lowest(pend_left);
`ifdef PUF_SEQ_MAJORITY_EN
          pass           <= 2'd0;
        end else begin
          smp[pass[0]]   <= meas_bit;
          pass           <= pass + 2'd1;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench for puf_challenge_sequencer with WINDOW=8, RST_CYCLES=2 and a
// table-driven engine model (T=16'hA5C3).
module tb_puf_challenge_sequencer;

  localparam int W = 8;
  localparam int R = 2;
`ifdef PUF_SEQ_MAJORITY_EN
  localparam int PASSES = 3;
`else
  localparam int PASSES = 1;
`endif
  localparam int PER = PASSES * (R + W + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] chal_mask;
  logic        busy;
  logic        done;
  logic [15:0] response;
  logic        meas_rst;
  logic        meas_valid;
  logic [3:0]  meas_challenge;
  logic        meas_bit;

  logic [15:0] T = 16'hA5C3;
  logic        ovr_en = 1'b0;
  logic        ovr_bit = 1'b0;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  bit busy_seen = 0;
  logic [3:0] chlog[$];

  assign meas_bit = ovr_en ? ovr_bit : T[meas_challenge];

  always #5 clk = ~clk;

  puf_challenge_sequencer #(.WINDOW(W), .RST_CYCLES(R)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .chal_mask(chal_mask),
    .busy(busy), .done(done), .response(response), .meas_rst(meas_rst),
    .meas_valid(meas_valid), .meas_challenge(meas_challenge), .meas_bit(meas_bit)
  );

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) begin
      busy_seen = 1;
      if (chlog.size() == 0 || chlog[$] != meas_challenge) chlog.push_back(meas_challenge);
    end
  end

  task automatic clear_mon();
    chlog.delete();
    busy_seen = 0;
    done_cnt  = 0;
  endtask

  // start is assumed raised at the preceding negedge; returns cycles until done
  task automatic wait_done(input int limit, output int lat);
    lat = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; chal_mask = 16'h0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (response !== 16'h0) begin errors++; $display("FAIL reset_resp got=%h exp=0000", response); end
    checks++; if (meas_rst !== 1'b1) begin errors++; $display("FAIL reset_meas_rst got=%b exp=1", meas_rst); end
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_meas_valid got=%b exp=0", meas_valid); end
    checks++; if (meas_challenge !== 4'd0) begin errors++; $display("FAIL reset_chal got=%0d exp=0", meas_challenge); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_mask();
    int lat;
    int bad;
    clear_mon();
    chal_mask = 16'hFFFF; start = 1'b1;
    wait_done(1000, lat);
    checks++; if (lat !== 1 + 16 * PER) begin errors++; $display("FAIL full_latency got=%0d exp=%0d", lat, 1 + 16 * PER); end
    checks++; if (response !== 16'hA5C3) begin errors++; $display("FAIL full_resp got=%h exp=a5c3", response); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_in_done got=%b exp=0", busy); end
    bad = (chlog.size() == 16) ? 0 : 1;
    foreach (chlog[i]) if (chlog[i] != 4'(i)) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_chal_seq got=%0d_entries exp=16_in_order", chlog.size()); end
    @(negedge clk);
    checks++; if (meas_rst !== 1'b1 || meas_valid !== 1'b0 || done !== 1'b0)
      begin errors++; $display("FAIL full_idle_outs got=%b%b%b exp=100", meas_rst, meas_valid, done); end
  endtask

  task automatic test_zero_mask();
    int lat;
    clear_mon();
    chal_mask = 16'h0000; start = 1'b1;
    wait_done(20, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL zero_busy got=%b exp=0", busy_seen); end
    checks++; if (response !== 16'h0) begin errors++; $display("FAIL zero_resp got=%h exp=0000", response); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit hit;
    clear_mon();
    chal_mask = 16'h8001; start = 1'b1;
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (meas_valid && meas_challenge == 4'd15) begin hit = 1; break; end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL abort_reach_ch15 got=%b exp=1", hit); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || meas_rst !== 1'b1 || meas_valid !== 1'b0)
      begin errors++; $display("FAIL abort_idle got=%b%b%b exp=010", busy, meas_rst, meas_valid); end
    repeat (30) @(negedge clk);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
    checks++; if (response !== 16'h0001) begin errors++; $display("FAIL abort_resp got=%h exp=0001", response); end
    // start together with abort in IDLE must not launch
    clear_mon();
    chal_mask = 16'h0001; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy_seen !== 1'b0 || done_cnt !== 0)
      begin errors++; $display("FAIL start_abort_idle got=%b/%0d exp=0/0", busy_seen, done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit hit;
    int lat;
    clear_mon();
    chal_mask = 16'h000F; start = 1'b1;
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (meas_valid && meas_challenge == 4'd3) begin hit = 1; break; end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rstmid_reach_ch3 got=%b exp=1", hit); end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || response !== 16'h0 || meas_rst !== 1'b1 ||
                  meas_valid !== 1'b0 || meas_challenge !== 4'd0)
      begin errors++; $display("FAIL rstmid_outs got=%b%b_%h_%b%b_%0d exp=00_0000_10_0",
                               busy, done, response, meas_rst, meas_valid, meas_challenge); end
    @(negedge clk);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt); end
    chal_mask = 16'h0008; start = 1'b1;
    wait_done(200, lat);
    checks++; if (lat !== 1 + PER) begin errors++; $display("FAIL rstmid_latency got=%0d exp=%0d", lat, 1 + PER); end
    checks++; if (response !== 16'h0000) begin errors++; $display("FAIL rstmid_resp got=%h exp=0000", response); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    clear_mon();
    chal_mask = 16'h0006; start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 500; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 15);
      if (c == 5) chal_mask = 16'hFFFF;
      if (done) begin lat = c; break; end
    end
    start = 1'b0;
    checks++; if (lat !== 1 + 2 * PER) begin errors++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, 1 + 2 * PER); end
    checks++; if (response !== 16'h0002) begin errors++; $display("FAIL b2b_resp got=%h exp=0002", response); end
    checks++; if (chlog.size() != 2 || chlog[0] != 4'd1 || chlog[chlog.size()-1] != 4'd2)
      begin errors++; $display("FAIL b2b_chal_seq got=%0d_entries exp=2 (1,2)", chlog.size()); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_no_relaunch got=%b exp=0", busy); end
  endtask

`ifdef PUF_SEQ_MAJORITY_EN
  task automatic test_majority(input logic [2:0] seq, input logic exp_bit);
    int lat;
    int idx;
    ovr_en = 1'b1;
    chal_mask = 16'h0001; start = 1'b1;
    ovr_bit = seq[0];
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      start = 1'b0;
      idx = (c - 1) / (R + W + 1);
      if (idx > 2) idx = 2;
      ovr_bit = seq[idx];
      if (done) begin lat = c; break; end
    end
    ovr_en = 1'b0;
    checks++; if (lat !== 34) begin errors++; $display("FAIL maj_latency got=%0d exp=34", lat); end
    checks++; if (response !== {15'd0, exp_bit}) begin errors++; $display("FAIL maj_resp got=%h exp=%h", response, {15'd0, exp_bit}); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_full_mask();
    test_zero_mask();
    test_abort();
    test_reset_mid();
    test_back_to_back();
`ifdef PUF_SEQ_MAJORITY_EN
    test_majority(3'b101, 1'b1);
    test_majority(3'b001, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
